// File: rtl/ctrl_pipeline.sv
// Pipelines decoder control bits ID->EX->MEM->WB; generates load-use stall, branch/jump flush, EX forwarding selects.
// Latency: ex_* 1 edge, mem_* 2 edges, wb_* 3 edges after ID; stall/flush/forward are combinational.
module ctrl_pipeline #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_add,
  input  logic             id_memwrite,
  input  logic             id_regwrite,
  input  logic             id_immediate,
  input  logic [1:0]       id_toreg,
  input  logic [1:0]       id_jump,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_take,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_add,
  output logic             ex_memwrite,
  output logic             ex_regwrite,
  output logic             ex_immediate,
  output logic [1:0]       ex_toreg,
  output logic [1:0]       ex_jump,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             mem_regwrite,
  output logic [1:0]       mem_toreg,
  output logic [4:0]       mem_rd,
  output logic             wb_regwrite,
  output logic [1:0]       wb_toreg,
  output logic [4:0]       wb_rd,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       add;
    logic       memwrite;
    logic       regwrite;
    logic       immediate;
    logic [1:0] toreg;
    logic [1:0] jump;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] toreg;
    logic [4:0] rd;
  } exmem_t;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] toreg;
    logic [4:0] rd;
  } memwb_t;

  idex_t      ex_q, ex_d;
  exmem_t     mem_q, mem_d;
  memwb_t     wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic       load_use;

  assign flush    = (ex_q.branch & ex_take) | (ex_q.jump != 2'b00);
  assign load_use = ex_q.memread & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & id_valid;
  // A squashed ID instruction need not wait for the load.
  assign stall    = load_use & ~flush;

  function automatic logic [1:0] fwd_sel(input exmem_t m, input memwb_t w, input logic [4:0] rs);
    if (m.regwrite && m.rd != 5'd0 && m.rd == rs)      fwd_sel = 2'b10;
    else if (w.regwrite && w.rd != 5'd0 && w.rd == rs) fwd_sel = 2'b01;
    else                                               fwd_sel = 2'b00;
  endfunction

  assign forward_a = fwd_sel(mem_q, wb_q, ex_q.rs1);
  assign forward_b = fwd_sel(mem_q, wb_q, ex_q.rs2);

  always_comb begin
    ex_d = '{branch: id_branch, memread: id_memread, add: id_add, memwrite: id_memwrite,
             regwrite: id_regwrite, immediate: id_immediate, toreg: id_toreg, jump: id_jump,
             rs1: id_rs1, rs2: id_rs2, rd: id_rd};
    if (flush || stall || !id_valid) ex_d = '0;
    mem_d = '{memread: ex_q.memread, memwrite: ex_q.memwrite, regwrite: ex_q.regwrite,
              toreg: ex_q.toreg, rd: ex_q.rd};
    wb_d  = '{regwrite: mem_q.regwrite, toreg: mem_q.toreg, rd: mem_q.rd};
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_branch    = ex_q.branch;
  assign ex_memread   = ex_q.memread;
  assign ex_add       = ex_q.add;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_immediate = ex_q.immediate;
  assign ex_toreg     = ex_q.toreg;
  assign ex_jump      = ex_q.jump;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_regwrite = mem_q.regwrite;
  assign mem_toreg    = mem_q.toreg;
  assign mem_rd       = mem_q.rd;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_toreg     = wb_q.toreg;
  assign wb_rd        = wb_q.rd;
  assign stall_count  = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed table plus randomized traffic for ctrl_pipeline, checked against an instruction-history model.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       memread;
    logic       add;
    logic       memwrite;
    logic       regwrite;
    logic       immediate;
    logic [1:0] toreg;
    logic [1:0] jump;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_t;

  typedef struct {
    logic       rst;
    id_t        id;
    logic       take;
    logic       e_stall;
    logic       e_flush;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic [4:0] e_exrd;
    logic       e_wbrw;
    logic [1:0] e_wbtoreg;
    int         e_sc;
    int         e_fc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_branch, id_memread, id_add, id_memwrite, id_regwrite, id_immediate;
  logic [1:0] id_toreg, id_jump;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_take;

  logic ex_branch, ex_memread, ex_add, ex_memwrite, ex_regwrite, ex_immediate;
  logic [1:0] ex_toreg, ex_jump;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic mem_memread, mem_memwrite, mem_regwrite;
  logic [1:0] mem_toreg;
  logic [4:0] mem_rd;
  logic wb_regwrite;
  logic [1:0] wb_toreg;
  logic [4:0] wb_rd;
  logic [1:0] forward_a, forward_b;
  logic stall, flush;
  logic [31:0] stall_count, flush_count;

  logic s_ex_branch, s_ex_memread, s_ex_add, s_ex_memwrite, s_ex_regwrite, s_ex_immediate;
  logic [1:0] s_ex_toreg, s_ex_jump;
  logic [4:0] s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic s_mem_memread, s_mem_memwrite, s_mem_regwrite;
  logic [1:0] s_mem_toreg;
  logic [4:0] s_mem_rd;
  logic s_wb_regwrite;
  logic [1:0] s_wb_toreg;
  logic [4:0] s_wb_rd;
  logic [1:0] s_forward_a, s_forward_b;
  logic s_stall, s_flush;
  logic [3:0] s_stall_count, s_flush_count;

  ctrl_pipeline u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch), .id_memread(id_memread),
    .id_add(id_add), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite), .id_immediate(id_immediate),
    .id_toreg(id_toreg), .id_jump(id_jump), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_take(ex_take), .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_add(ex_add),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_immediate(ex_immediate),
    .ex_toreg(ex_toreg), .ex_jump(ex_jump), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
    .mem_toreg(mem_toreg), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_toreg(wb_toreg),
    .wb_rd(wb_rd), .forward_a(forward_a), .forward_b(forward_b), .stall(stall), .flush(flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  ctrl_pipeline #(.CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_branch(id_branch), .id_memread(id_memread),
    .id_add(id_add), .id_memwrite(id_memwrite), .id_regwrite(id_regwrite), .id_immediate(id_immediate),
    .id_toreg(id_toreg), .id_jump(id_jump), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_take(ex_take), .ex_branch(s_ex_branch), .ex_memread(s_ex_memread), .ex_add(s_ex_add),
    .ex_memwrite(s_ex_memwrite), .ex_regwrite(s_ex_regwrite), .ex_immediate(s_ex_immediate),
    .ex_toreg(s_ex_toreg), .ex_jump(s_ex_jump), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
    .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite), .mem_regwrite(s_mem_regwrite),
    .mem_toreg(s_mem_toreg), .mem_rd(s_mem_rd), .wb_regwrite(s_wb_regwrite), .wb_toreg(s_wb_toreg),
    .wb_rd(s_wb_rd), .forward_a(s_forward_a), .forward_b(s_forward_b), .stall(s_stall), .flush(s_flush),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  int checks = 0;
  int failures = 0;

  // hist[0] is the instruction now in EX, hist[1] in MEM, hist[2] in WB.
  id_t hist [3];
  longint unsigned m_sc, m_fc;
  logic m_fl, m_st;
  logic [1:0] m_fa, m_fb;
  vec_t tbl [22];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 0 && hist[1].regwrite && hist[1].rd == rs) return 2'b10;
    if (rs != 0 && hist[2].regwrite && hist[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic id_t mk(input logic v, input logic br, input logic mr, input logic mw,
                             input logic rw, input logic [1:0] tr, input logic [1:0] jp,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    id_t x;
    x = '{valid: v, branch: br, memread: mr, add: 1'b0, memwrite: mw, regwrite: rw,
          immediate: 1'b0, toreg: tr, jump: jp, rs1: s1, rs2: s2, rd: d};
    return x;
  endfunction

  // Drives one cycle's inputs and compares every output with the model before the edge.
  task automatic apply(input logic r, input id_t d, input logic t);
    id_t e;
    logic hazard;
    reset = r; ex_take = t;
    id_valid = d.valid; id_branch = d.branch; id_memread = d.memread; id_add = d.add;
    id_memwrite = d.memwrite; id_regwrite = d.regwrite; id_immediate = d.immediate;
    id_toreg = d.toreg; id_jump = d.jump; id_rs1 = d.rs1; id_rs2 = d.rs2; id_rd = d.rd;
    #2;
    e = hist[0];
    m_fl = (e.branch && t) || (e.jump != 2'b00);
    hazard = d.valid && e.memread && e.rd != 0 && (e.rd == d.rs1 || e.rd == d.rs2);
    m_st = hazard && !m_fl;
    m_fa = ref_fwd(e.rs1);
    m_fb = ref_fwd(e.rs2);
    chk("ex_ctrl", {ex_branch, ex_memread, ex_add, ex_memwrite, ex_regwrite, ex_immediate,
                    ex_toreg, ex_jump, ex_rs1, ex_rs2, ex_rd}, 64'(e[24:0]));
    chk("mem_ctrl", {mem_memread, mem_memwrite, mem_regwrite, mem_toreg, mem_rd},
        {hist[1].memread, hist[1].memwrite, hist[1].regwrite, hist[1].toreg, hist[1].rd});
    chk("wb_ctrl", {wb_regwrite, wb_toreg, wb_rd}, {hist[2].regwrite, hist[2].toreg, hist[2].rd});
    chk("forward", {forward_a, forward_b}, {m_fa, m_fb});
    chk("stall_flush", {stall, flush}, {m_st, m_fl});
    chk("counters", {stall_count, flush_count}, {m_sc[31:0], m_fc[31:0]});
    chk("small_counters", {s_stall_count, s_flush_count},
        {4'((m_sc > 15) ? 15 : m_sc), 4'((m_fc > 15) ? 15 : m_fc)});
  endtask

  task automatic advance(input logic r, input id_t d);
    @(posedge clk); #1;
    if (r) begin
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      m_sc = 0; m_fc = 0;
    end else begin
      if (m_st && m_sc < 64'hFFFF_FFFF) m_sc++;
      if (m_fl && m_fc < 64'hFFFF_FFFF) m_fc++;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (m_fl || m_st || !d.valid) ? id_t'('0) : d;
    end
  endtask

  initial begin
    id_t NZ, LW, ADD6, BUB, ADD1, ADD2, SUB, ADDX0, I7, BEQ, I8, JL9, I10, JALR, JAL, rnd;
    logic rr, rt;
    NZ    = mk(1, 1, 1, 1, 1, 2'd2, 2'd3, 5'd3, 5'd4, 5'd3);
    LW    = mk(1, 0, 1, 0, 1, 2'd1, 2'd0, 5'd2, 5'd0, 5'd5);
    ADD6  = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd5, 5'd7, 5'd6);
    BUB   = '0;
    ADD1  = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd0, 5'd0, 5'd1);
    ADD2  = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd0, 5'd0, 5'd2);
    SUB   = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd1, 5'd2, 5'd3);
    ADDX0 = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0);
    I7    = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd0, 5'd0, 5'd7);
    BEQ   = mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 5'd3, 5'd4, 5'd0);
    I8    = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd3, 5'd0, 5'd8);
    JL9   = mk(1, 0, 1, 0, 1, 2'd0, 2'd1, 5'd0, 5'd0, 5'd9);
    I10   = mk(1, 0, 0, 0, 1, 2'd0, 2'd0, 5'd9, 5'd0, 5'd10);
    JALR  = mk(1, 0, 0, 0, 1, 2'd2, 2'd3, 5'd1, 5'd0, 5'd1);
    JAL   = mk(1, 0, 0, 0, 1, 2'd2, 2'd1, 5'd0, 5'd0, 5'd1);

    //             rst id     tk  stl fl fa     fb     exrd  wbrw wbtr  sc fc
    tbl[0]  = '{1'b1, NZ,    0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 0, 0};
    tbl[1]  = '{1'b1, NZ,    0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 0, 0};
    tbl[2]  = '{1'b0, LW,    0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 0, 0};
    tbl[3]  = '{1'b0, ADD6,  0, 1, 0, 2'd0, 2'd0, 5'd5, 0, 2'd0, 0, 0};
    tbl[4]  = '{1'b0, ADD6,  0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 1, 0};
    tbl[5]  = '{1'b0, BUB,   0, 0, 0, 2'd1, 2'd0, 5'd6, 1, 2'd1, 1, 0};
    tbl[6]  = '{1'b0, ADD1,  0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 1, 0};
    tbl[7]  = '{1'b0, ADD2,  0, 0, 0, 2'd0, 2'd0, 5'd1, 1, 2'd0, 1, 0};
    tbl[8]  = '{1'b0, SUB,   0, 0, 0, 2'd0, 2'd0, 5'd2, 0, 2'd0, 1, 0};
    tbl[9]  = '{1'b0, ADDX0, 0, 0, 0, 2'd1, 2'd2, 5'd3, 1, 2'd0, 1, 0};
    tbl[10] = '{1'b0, I7,    0, 0, 0, 2'd0, 2'd0, 5'd0, 1, 2'd0, 1, 0};
    tbl[11] = '{1'b0, BUB,   0, 0, 0, 2'd0, 2'd0, 5'd7, 1, 2'd0, 1, 0};
    tbl[12] = '{1'b0, BEQ,   0, 0, 0, 2'd0, 2'd0, 5'd0, 1, 2'd0, 1, 0};
    tbl[13] = '{1'b0, I8,    1, 0, 1, 2'd0, 2'd0, 5'd0, 1, 2'd0, 1, 0};
    tbl[14] = '{1'b0, I8,    0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 1, 1};
    tbl[15] = '{1'b0, JL9,   0, 0, 0, 2'd0, 2'd0, 5'd8, 0, 2'd0, 1, 1};
    tbl[16] = '{1'b0, I10,   0, 0, 1, 2'd0, 2'd0, 5'd9, 0, 2'd0, 1, 1};
    tbl[17] = '{1'b0, BUB,   0, 0, 0, 2'd0, 2'd0, 5'd0, 1, 2'd0, 1, 2};
    tbl[18] = '{1'b0, JALR,  0, 0, 0, 2'd0, 2'd0, 5'd0, 1, 2'd0, 1, 2};
    tbl[19] = '{1'b0, BUB,   0, 0, 1, 2'd0, 2'd0, 5'd1, 0, 2'd0, 1, 2};
    tbl[20] = '{1'b0, BUB,   0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 2'd0, 1, 3};
    tbl[21] = '{1'b0, BUB,   0, 0, 0, 2'd0, 2'd0, 5'd0, 1, 2'd2, 1, 3};

    // Registers start unknown; one reset edge puts DUT and model in the same state.
    apply(1'b1, BUB, 1'b0);
    checks = 0;
    failures = 0;
    advance(1'b1, BUB);

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].rst, tbl[i].id, tbl[i].take);
      chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_flush", i), 64'(flush), 64'(tbl[i].e_flush));
      chk($sformatf("tbl%0d_fwd", i), {forward_a, forward_b}, {tbl[i].e_fa, tbl[i].e_fb});
      chk($sformatf("tbl%0d_ex_rd", i), 64'(ex_rd), 64'(tbl[i].e_exrd));
      chk($sformatf("tbl%0d_wb", i), {wb_regwrite, wb_toreg}, {tbl[i].e_wbrw, tbl[i].e_wbtoreg});
      chk($sformatf("tbl%0d_cnt", i), {stall_count, flush_count},
          {32'(tbl[i].e_sc), 32'(tbl[i].e_fc)});
      advance(tbl[i].rst, tbl[i].id);
    end

    // A jal re-presented every cycle flushes on alternate cycles: 40 cycles give 20 flushes.
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, JAL, 1'b0);
      advance(1'b0, JAL);
    end
    apply(1'b0, BUB, 1'b0);
    chk("small_flush_saturated", 64'(s_flush_count), 64'd15);
    chk("wide_flush_count", 64'(flush_count), 64'd23);
    advance(1'b0, BUB);

    for (int i = 0; i < 3000; i++) begin
      rnd = id_t'($urandom);
      rnd.rs1 = 5'($urandom_range(0, 7));
      rnd.rs2 = 5'($urandom_range(0, 7));
      rnd.rd  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) rnd.jump = 2'b00;
      rr = ($urandom_range(0, 49) == 0);
      rt = 1'($urandom);
      apply(rr, rnd, rt);
      advance(rr, rnd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
